// File: rtl/rlwe_dmem_arb.sv
// Two-master DMEM arbiter: scalar LSU (m0) and RLWE vector unit (m1)
// share one DMEM port, with round-robin on contention, a single
// outstanding transaction, and a response timeout.
module rlwe_dmem_arb #(
  parameter int unsigned LANE    = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_cmd,
  input  logic [1:0]           m0_width,
  input  logic [AW-1:0]        m0_addr,
  input  logic [LANE*32-1:0]   m0_wdata,
  output logic                 m0_req_ack,
  output logic [LANE*32-1:0]   m0_rdata,
  output logic [1:0]           m0_resp,
  input  logic                 m1_req,
  input  logic                 m1_cmd,
  input  logic [1:0]           m1_width,
  input  logic [AW-1:0]        m1_addr,
  input  logic [LANE*32-1:0]   m1_wdata,
  output logic                 m1_req_ack,
  output logic [LANE*32-1:0]   m1_rdata,
  output logic [1:0]           m1_resp,
  output logic                 dmem_req,
  output logic                 dmem_cmd,
  output logic [1:0]           dmem_width,
  output logic [AW-1:0]        dmem_addr,
  output logic [LANE*32-1:0]   dmem_wdata,
  input  logic                 dmem_req_ack,
  input  logic [LANE*32-1:0]   dmem_rdata,
  input  logic [1:0]           dmem_resp,
  output logic                 busy,
  output logic                 arb_err
);

  localparam int unsigned DW  = LANE * 32;
  localparam logic [9:0]  TMO = 10'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic          owner, last_gnt;
  logic [9:0]    timer;
  logic          any_req, winner, grant;
  logic [1:0]    resp_v;
  logic [DW-1:0] rdata_v;

  // Winner selection: a lone requester wins, contention goes to whoever was not granted last
  always_comb begin
    any_req = m0_req | m1_req;
    winner  = (m0_req && m1_req) ? ~last_gnt : m1_req;
    grant   = (state == S_IDLE) && any_req && dmem_req_ack;
  end

  // Next state and all outputs; everything is forced quiet while rst is high
  always_comb begin
    state_nxt  = state;
    dmem_req   = 1'b0;
    dmem_cmd   = 1'b0;
    dmem_width = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    m0_req_ack = 1'b0;
    m1_req_ack = 1'b0;
    m0_resp    = '0;
    m1_resp    = '0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    busy       = 1'b0;
    arb_err    = 1'b0;
    resp_v     = '0;
    rdata_v    = '0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          dmem_req = any_req;
          if (any_req) begin
            dmem_cmd   = winner ? m1_cmd   : m0_cmd;
            dmem_width = winner ? m1_width : m0_width;
            dmem_addr  = winner ? m1_addr  : m0_addr;
            dmem_wdata = winner ? m1_wdata : m0_wdata;
          end
          m0_req_ack = dmem_req_ack & any_req & ~winner;
          m1_req_ack = dmem_req_ack & any_req & winner;
          // any response with nothing outstanding is stray or late
          arb_err    = (dmem_resp != 2'b00);
          if (grant) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          busy = 1'b1;
          case (dmem_resp)
            2'b00: begin
              rdata_v = dmem_rdata;
              if (timer == TMO) begin
                resp_v    = 2'b10;
                rdata_v   = '0;
                arb_err   = 1'b1;
                state_nxt = S_IDLE;
              end
            end
            2'b11: begin
              resp_v    = 2'b10;
              arb_err   = 1'b1;
              state_nxt = S_IDLE;
            end
            default: begin
              resp_v    = dmem_resp;
              rdata_v   = dmem_rdata;
              state_nxt = S_IDLE;
            end
          endcase
          if (owner) begin
            m1_resp  = resp_v;
            m1_rdata = rdata_v;
          end else begin
            m0_resp  = resp_v;
            m0_rdata = rdata_v;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, ownership, round-robin history and saturating WAIT timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      timer    <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner    <= winner;
        last_gnt <= winner;
        timer    <= '0;
      end else if (state == S_WAIT && timer != TMO) begin
        timer <= timer + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_rlwe_dmem_arb.sv
// Cycle-by-cycle vector bench for rlwe_dmem_arb (TIMEOUT=4), plus an
// asynchronous-reset-in-WAIT sequence.
module tb_rlwe_dmem_arb;

  localparam int unsigned LANE = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = LANE * 32;

  localparam logic [DW-1:0] D  = 128'h0000_0000_0000_0000_1111_2222_3333_4444;
  localparam logic [DW-1:0] D2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
  localparam logic [DW-1:0] Z  = '0;
  localparam logic [DW-1:0] W0 = 128'hA0A0_A0A0_B1B1_B1B1_C2C2_C2C2_D3D3_D3D3;
  localparam logic [DW-1:0] W1 = 128'h0F0F_0F0F_1E1E_1E1E_2D2D_2D2D_3C3C_3C3C;

  logic clk, rst;
  logic m0_req, m0_cmd, m0_req_ack, m1_req, m1_cmd, m1_req_ack;
  logic [1:0] m0_width, m1_width, m0_resp, m1_resp, dmem_width, dmem_resp;
  logic [AW-1:0] m0_addr, m1_addr, dmem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, dmem_wdata, dmem_rdata;
  logic dmem_req, dmem_cmd, dmem_req_ack, busy, arb_err;

  rlwe_dmem_arb #(.LANE(LANE), .AW(AW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_req_ack(m0_req_ack), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_req_ack(m1_req_ack), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .busy(busy), .arb_err(arb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rst, r0, r1, ack;
    bit [1:0]    resp;
    bit [DW-1:0] rd;
    bit          dreq;
    bit [1:0]    win;   // 0 none, 1 m0, 2 m1
    bit          a0, a1;
    bit [1:0]    p0, p1;
    bit [DW-1:0] d0, d1;
    bit          busy, err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(bit rs, bit r0, bit r1, bit ack, bit [1:0] resp, bit [DW-1:0] rd,
                              bit dreq, bit [1:0] win, bit a0, bit a1, bit [1:0] p0, bit [1:0] p1,
                              bit [DW-1:0] d0, bit [DW-1:0] d1, bit bz, bit err);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.r1 = r1; v.ack = ack; v.resp = resp; v.rd = rd;
    v.dreq = dreq; v.win = win; v.a0 = a0; v.a1 = a1; v.p0 = p0; v.p1 = p1;
    v.d0 = d0; v.d1 = d1; v.busy = bz; v.err = err;
    return v;
  endfunction

  // Expected {cmd,width,addr,wdata} on the DMEM side for a given winner code
  function automatic logic [255:0] bundle(bit [1:0] win);
    case (win)
      2'd1:    return {93'd0, 1'b1, 2'b10, 32'h0000_0100, W0};
      2'd2:    return {93'd0, 1'b0, 2'b11, 32'h0000_0040, W1};
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic quiet();
    tbl.push_back(mk(0,0,0,0,0,Z, 0,0,0,0,0,0,Z,Z,0,0));
  endtask

  task automatic waiting(input int n);
    for (int k = 0; k < n; k++) tbl.push_back(mk(0,0,0,0,0,Z, 0,0,0,0,0,0,Z,Z,1,0));
  endtask

  initial begin
    vec_t v, e;
    string t;
    rst = 1'b1; m0_req = 0; m1_req = 0; dmem_req_ack = 0; dmem_resp = '0; dmem_rdata = '0;
    m0_cmd = 1'b1; m0_width = 2'b10; m0_addr = 32'h100; m0_wdata = W0;
    m1_cmd = 1'b0; m1_width = 2'b11; m1_addr = 32'h40;  m1_wdata = W1;

    // reset holds all outputs quiet even with requests, ack and a response present
    tbl.push_back(mk(1,1,1,1,1,D, 0,0,0,0,0,0,Z,Z,0,0));
    // single m1 vector read, response in cycle 3
    tbl.push_back(mk(0,0,1,1,0,Z, 1,2,0,1,0,0,Z,Z,0,0));
    waiting(2);
    tbl.push_back(mk(0,0,0,0,1,D, 0,0,0,0,0,1,Z,D,1,0));
    quiet();
    // back-pressure: m0 held, no ack for 5 cycles, then acked
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,1,0,0,0,Z, 1,1,0,0,0,0,Z,Z,0,0));
    tbl.push_back(mk(0,1,0,1,0,Z, 1,1,1,0,0,0,Z,Z,0,0));
    // timeout 4 cycles after entering WAIT, then a late response
    waiting(4);
    tbl.push_back(mk(0,0,0,0,0,Z, 0,0,0,0,2,0,Z,Z,1,1));
    quiet();
    tbl.push_back(mk(0,0,0,0,1,D, 0,0,0,0,0,0,Z,Z,0,1));
    quiet();
    // contention from reset: m0, m1, m0 (error resp), m1 (resp 11)
    tbl.push_back(mk(1,1,1,1,0,Z, 0,0,0,0,0,0,Z,Z,0,0));
    tbl.push_back(mk(0,1,1,1,0,Z, 1,1,1,0,0,0,Z,Z,0,0));
    tbl.push_back(mk(0,1,1,1,1,D, 0,0,0,0,1,0,D,Z,1,0));
    tbl.push_back(mk(0,1,1,1,0,Z, 1,2,0,1,0,0,Z,Z,0,0));
    tbl.push_back(mk(0,1,1,1,1,D2, 0,0,0,0,0,1,Z,D2,1,0));
    tbl.push_back(mk(0,1,1,1,0,Z, 1,1,1,0,0,0,Z,Z,0,0));
    tbl.push_back(mk(0,1,1,1,2,Z, 0,0,0,0,2,0,Z,Z,1,0));
    tbl.push_back(mk(0,1,1,1,0,Z, 1,2,0,1,0,0,Z,Z,0,0));
    tbl.push_back(mk(0,1,1,1,3,D, 0,0,0,0,0,2,Z,Z,1,1));
    quiet();
    // response coinciding with timeout: response wins, no error
    tbl.push_back(mk(0,0,1,1,0,Z, 1,2,0,1,0,0,Z,Z,0,0));
    waiting(4);
    tbl.push_back(mk(0,0,0,0,1,D, 0,0,0,0,0,1,Z,D,1,0));
    quiet();
    // reset while m1 outstanding, then its late response
    tbl.push_back(mk(0,0,1,1,0,Z, 1,2,0,1,0,0,Z,Z,0,0));
    waiting(1);
    tbl.push_back(mk(1,0,0,0,0,Z, 0,0,0,0,0,0,Z,Z,0,0));
    tbl.push_back(mk(0,0,0,0,1,D, 0,0,0,0,0,0,Z,Z,0,1));
    quiet();
    // winner drops its request before ack: no grant
    tbl.push_back(mk(0,1,0,0,0,Z, 1,1,0,0,0,0,Z,Z,0,0));
    tbl.push_back(mk(0,0,0,1,0,Z, 0,0,0,0,0,0,Z,Z,0,0));
    quiet();

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      v = tbl[i];
      rst = v.rst; m0_req = v.r0; m1_req = v.r1; dmem_req_ack = v.ack;
      dmem_resp = v.resp; dmem_rdata = v.rd;
      exp_q.push_back(v);
      #2;
      e = exp_q.pop_front();
      t = $sformatf("row%0d", i);
      chk({t, " dmem_req"}, 256'(dmem_req), 256'(e.dreq));
      chk({t, " acks"}, 256'({m0_req_ack, m1_req_ack}), 256'({e.a0, e.a1}));
      chk({t, " m0_resp"}, 256'(m0_resp), 256'(e.p0));
      chk({t, " m1_resp"}, 256'(m1_resp), 256'(e.p1));
      chk({t, " m0_rdata"}, 256'(m0_rdata), 256'(e.d0));
      chk({t, " m1_rdata"}, 256'(m1_rdata), 256'(e.d1));
      chk({t, " busy"}, 256'(busy), 256'(e.busy));
      chk({t, " arb_err"}, 256'(arb_err), 256'(e.err));
      if (!e.busy)
        chk({t, " dmem_bundle"}, 256'({dmem_cmd, dmem_width, dmem_addr, dmem_wdata}), bundle(e.win));
    end

    // asynchronous reset mid-cycle while m1 waits, with a response present during reset
    @(negedge clk);
    m1_req = 1'b1; dmem_req_ack = 1'b1; dmem_resp = 2'b00;
    #2 chk("async m1_req_ack", 256'(m1_req_ack), 256'(1));
    @(negedge clk);
    m1_req = 1'b0; dmem_req_ack = 1'b0;
    #1 chk("async busy_before", 256'(busy), 256'(1));
    #1 rst = 1'b1;
    #1 chk("async busy_after", 256'(busy), 256'(0));
    dmem_resp = 2'b01; dmem_rdata = D;
    #1 chk("async m1_resp", 256'(m1_resp), 256'(0));
    chk("async m1_rdata", 256'(m1_rdata), 256'(0));
    chk("async arb_err", 256'(arb_err), 256'(0));
    @(negedge clk);
    rst = 1'b0; dmem_resp = 2'b00; dmem_rdata = '0;
    #2 chk("async idle_busy", 256'(busy), 256'(0));
    chk("async idle_m1_resp", 256'(m1_resp), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rlwe_dmem_arb.md
RLWE_DMEM_ARB -- requirements
Module: rlwe_dmem_arb

Interface
REQ-001 SHALL have parameter LANE, default 4: 32-bit lanes per data beat; data buses are LANE*32 bits.
REQ-002 SHALL have parameter AW, default 32: DMEM address width.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before the arbiter forces an error response; legal range 1..1023.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports m0_req/m1_req, input, 1: request from scalar LSU (m0) / RLWE vector unit (m1); held until acked.
REQ-007 SHALL have ports m0_cmd/m1_cmd, input, 1: 0 = read, 1 = write.
REQ-008 SHALL have ports m0_width/m1_width, input, 2: 00 byte, 01 hword, 10 word, 11 vector.
REQ-009 SHALL have ports m0_addr/m1_addr, input, AW, and m0_wdata/m1_wdata, input, LANE*32.
REQ-010 SHALL have ports m0_req_ack/m1_req_ack, output, 1; m0_rdata/m1_rdata, output, LANE*32; m0_resp/m1_resp, output, 2, encoded 00 idle, 01 ready-OK, 10 ready-error.
REQ-011 SHALL have ports dmem_req, dmem_cmd, dmem_width, dmem_addr and dmem_wdata, outputs, with widths 1, 1, 2, AW and LANE*32: the shared DMEM request.
REQ-012 SHALL have ports dmem_req_ack, input, 1; dmem_rdata, input, LANE*32; dmem_resp, input, 2, with the same encoding as mN_resp.
REQ-013 SHALL have port busy, output, 1 (high in WAIT), and port arb_err, output, 1 (one-cycle protocol/timeout pulse).

Function
REQ-014 SHALL implement a two-state FSM, IDLE and WAIT, allowing at most one transaction outstanding on DMEM.
REQ-015 In IDLE: dmem_req = m0_req | m1_req, combinationally.
REQ-016 Winner selection:
- Only one requester active: that requester wins.
- Both active: the requester not granted last wins (round-robin).
- last_gnt resets to 1, so m0 wins the first contention.
REQ-017 dmem_cmd, dmem_width, dmem_addr and dmem_wdata SHALL mux from the winner; when no request is active they SHALL be all zeros.
REQ-018 mN_req_ack SHALL equal dmem_req_ack & IDLE & (winner==N), combinationally; the loser sees ack=0 and keeps its request pending.
REQ-019 On an acked cycle: owner <= winner, last_gnt <= winner, timer <= 0, FSM -> WAIT.
REQ-020 In WAIT: dmem_req = 0, both req_acks = 0, and timer increments by 1 per cycle, saturating at TIMEOUT.
REQ-021 In WAIT, the owner's mN_resp and mN_rdata SHALL pass dmem_resp and dmem_rdata through combinationally; the non-owner sees resp 00 and rdata 0.
REQ-022 In WAIT, dmem_resp = 01 or 10 SHALL move the FSM -> IDLE.
REQ-023 The earliest next grant follows the response cycle by one cycle; there is no grant in the response cycle itself.
REQ-024 Timeout: in WAIT with timer==TIMEOUT and dmem_resp==00, the arbiter SHALL:
- drive the owner's resp = 10 and rdata = 0 for that cycle;
- pulse arb_err;
- move FSM -> IDLE.
REQ-025 Timeout and response in the same cycle: the real response wins; no arb_err.
REQ-026 A dmem_resp of 01 or 10 arriving in IDLE (stray, or late after a timeout) SHALL NOT be forwarded to either requester and SHALL pulse arb_err.
REQ-027 dmem_resp = 11 in WAIT SHALL be treated as an error: owner resp = 10, arb_err pulses, FSM -> IDLE.
REQ-028 The winner's mN_req dropping before ack SHALL cause no state change (protocol violation by the requester; not flagged).

Reset
REQ-029 While rst is high, the block SHALL hold:
- FSM = IDLE, owner = 0, last_gnt = 1, timer = 0;
- busy, arb_err, dmem_req and both req_acks = 0;
- both resp = 00 and all data outputs = 0.
REQ-030 Reset asserted in WAIT SHALL abandon the transaction with no response delivered; a later DMEM response is handled per REQ-026.

Verification
REQ-031 Single access: m1_req read vector at addr 0x40, ack in cycle 0, dmem_resp=01 with rdata=0x1111_2222_3333_4444 at cycle 3 -> m1_resp=01 with that data at cycle 3; busy high in cycles 1-3; m0_resp stays 00.
REQ-032 Contention from reset: m0_req and m1_req both high with ack always 1 -> grant order m0, m1, m0, m1; each grant one cycle after the previous response.
REQ-033 Timeout with TIMEOUT=4: grant m0, no response -> m0_resp=10 and arb_err=1 exactly 4 cycles after entering WAIT; a dmem_resp=01 two cycles later -> arb_err pulses again and nothing is forwarded.
REQ-034 Back-pressure: m0_req held with dmem_req_ack=0 for 5 cycles -> dmem_req high throughout, m0_req_ack follows ack, FSM stays IDLE.
REQ-035 Reset in WAIT: rst pulsed during m1 transaction -> all outputs return to reset values asynchronously; m1_resp never leaves 00.
